// File: rtl/incdec_sched.sv
// 3-requester round-robin scheduler sharing one registered inc/pass/dec datapath.
// Latency: gnt one cycle after the IDLE sample, response three cycles after it; no backpressure, one op per 4 cycles.
module incdec_sched #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           RST,
    input  logic [2:0]     req,
    input  logic [3*W-1:0] number_bus,
    input  logic [5:0]     op_bus,
    output logic [2:0]     gnt,
    output logic [W-1:0]   dp_number,
    output logic [1:0]     dp_select,
    input  logic [W-1:0]   dp_result,
    output logic [2:0]     rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] OP_PASS = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q;
    logic [1:0]     win_q, win_d;
    logic [W-1:0]   num_q, num_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   res_q;
    logic [2:0]     gnt_q;
    logic           take;

    // Winner is the first requester after the last one served, wrapping.
    always_comb begin
        win_d = 2'd0;
        case (ptr_q)
            2'd0:    win_d = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    win_d = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win_d = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        num_d = number_bus[0 +: W];
        op_d  = op_bus[1:0];
        case (win_d)
            2'd1: begin
                num_d = number_bus[W +: W];
                op_d  = op_bus[3:2];
            end
            2'd2: begin
                num_d = number_bus[2*W +: W];
                op_d  = op_bus[5:4];
            end
            default: ;
        endcase
    end

    assign take = (state_q == IDLE) && (req != 3'b000);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ptr_q   <= 2'd2;
            win_q   <= 2'd0;
            num_q   <= '0;
            op_q    <= 2'b00;
            res_q   <= '0;
            gnt_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            gnt_q   <= take ? (3'b001 << win_d) : 3'b000;
            if (take) begin
                ptr_q <= win_d;
                win_q <= win_d;
                num_q <= num_d;
                op_q  <= op_d;
            end
            if (state_q == WAIT) begin
                res_q <= dp_result;
            end
        end
    end

    // Reserved op is issued as a pass and reported as an error with zero data.
    always_comb begin
        gnt       = gnt_q;
        busy      = (state_q != IDLE);
        dp_number = '0;
        dp_select = OP_PASS;
        rsp_valid = 3'b000;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        if (state_q == ISSUE) begin
            dp_number = num_q;
            dp_select = (op_q == OP_RSVD) ? OP_PASS : op_q;
        end
        if (state_q == RESP) begin
            rsp_valid = 3'b001 << win_q;
            rsp_data  = (op_q == OP_RSVD) ? '0 : res_q;
            rsp_err   = (op_q == OP_RSVD);
        end
    end

endmodule

// File: tb/tb_incdec_sched.sv
// Directed bench for incdec_sched with a registered inc/pass/dec datapath model.
module tb_incdec_sched;

    logic        clk;
    logic        RST;
    logic [2:0]  req;
    logic [23:0] number_bus;
    logic [5:0]  op_bus;
    logic [2:0]  gnt;
    logic [7:0]  dp_number;
    logic [1:0]  dp_select;
    logic [7:0]  dp_result;
    logic [2:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    incdec_sched #(.W(8)) dut (
        .clk        (clk),
        .RST        (RST),
        .req        (req),
        .number_bus (number_bus),
        .op_bus     (op_bus),
        .gnt        (gnt),
        .dp_number  (dp_number),
        .dp_select  (dp_select),
        .dp_result  (dp_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared datapath: result registered one clock after number/select.
    initial dp_result = 8'h00;
    always @(posedge clk) begin
        case (dp_select)
            2'b00:   dp_result <= dp_number + 8'd1;
            2'b10:   dp_result <= dp_number - 8'd1;
            default: dp_result <= dp_number;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; req = 3'b000; number_bus = '0; op_bus = '0;
        tick(); tick();
        total++;
        if ({gnt, rsp_valid, rsp_err, busy} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000000", {gnt, rsp_valid, rsp_err, busy});
        end
        total++;
        if ({dp_number, dp_select, rsp_data} !== {8'h00, 2'b01, 8'h00}) begin
            bad++; $display("FAIL reset_data got=%h/%b/%h want=00/01/00", dp_number, dp_select, rsp_data);
        end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req = 3'b001; number_bus = {8'h00, 8'h00, 8'h41}; op_bus = 6'b000000;
        tick();
        req = 3'b000;
        total++;
        if (gnt !== 3'b001) begin bad++; $display("FAIL single_gnt got=%b want=001", gnt); end
        total++;
        if ({dp_number, dp_select} !== {8'h41, 2'b00}) begin
            bad++; $display("FAIL single_dp got=%h/%b want=41/00", dp_number, dp_select);
        end
        tick();
        total++;
        if ({gnt, rsp_valid, busy} !== {3'b000, 3'b000, 1'b1}) begin
            bad++; $display("FAIL single_wait got=%b/%b/%b want=000/000/1", gnt, rsp_valid, busy);
        end
        tick();
        total++;
        if ({rsp_valid, rsp_data, rsp_err} !== {3'b001, 8'h42, 1'b0}) begin
            bad++; $display("FAIL single_rsp got=%b/%h/%b want=001/42/0", rsp_valid, rsp_data, rsp_err);
        end
        tick();
        total++;
        if ({rsp_valid, busy, rsp_data} !== {3'b000, 1'b0, 8'h00}) begin
            bad++; $display("FAIL single_idle got=%b/%b/%h want=000/0/00", rsp_valid, busy, rsp_data);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] nums [3];
        logic [1:0] ops  [3];
        logic [7:0] exp  [3];
        nums = '{8'hFF, 8'h00, 8'h7A};
        ops  = '{2'b00, 2'b10, 2'b01};
        exp  = '{8'h00, 8'hFF, 8'h7A};
        for (int i = 0; i < 3; i++) begin
            req = 3'b010; number_bus = {8'h00, nums[i], 8'h00}; op_bus = {2'b00, ops[i], 2'b00};
            tick();
            req = 3'b000;
            total++;
            if (gnt !== 3'b010) begin bad++; $display("FAIL wrap_gnt[%0d] got=%b want=010", i, gnt); end
            tick(); tick();
            total++;
            if ({rsp_valid, rsp_data, rsp_err} !== {3'b010, exp[i], 1'b0}) begin
                bad++; $display("FAIL wrap_rsp[%0d] got=%b/%h/%b want=010/%h/0", i, rsp_valid, rsp_data, rsp_err, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_reserved();
        req = 3'b100; number_bus = {8'h55, 8'h00, 8'h00}; op_bus = 6'b110000;
        tick();
        req = 3'b000;
        total++;
        if ({gnt, dp_number, dp_select} !== {3'b100, 8'h55, 2'b01}) begin
            bad++; $display("FAIL rsvd_issue got=%b/%h/%b want=100/55/01", gnt, dp_number, dp_select);
        end
        tick(); tick();
        total++;
        if ({rsp_valid, rsp_data, rsp_err} !== {3'b100, 8'h00, 1'b1}) begin
            bad++; $display("FAIL rsvd_rsp got=%b/%h/%b want=100/00/1", rsp_valid, rsp_data, rsp_err);
        end
        tick();
        total++;
        if (rsp_err !== 1'b0) begin bad++; $display("FAIL rsvd_err_clear got=%b want=0", rsp_err); end
    endtask

    task automatic test_drop();
        req = 3'b010;
        #2;
        req = 3'b000;
        tick();
        total++;
        if ({gnt, busy} !== 4'b0000) begin bad++; $display("FAIL drop got=%b want=0000", {gnt, busy}); end
    endtask

    task automatic test_fairness();
        logic [2:0] order [4];
        logic [2:0] want;
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
        RST = 1'b0;
        tick();
        RST = 1'b1;
        req = 3'b111; number_bus = {8'h30, 8'h20, 8'h10}; op_bus = 6'b010101;
        for (int i = 1; i < 16; i++) begin
            tick();
            want = (i % 4 == 1) ? order[i / 4] : 3'b000;
            total++;
            if (gnt !== want) begin bad++; $display("FAIL fair_gnt[%0d] got=%b want=%b", i, gnt, want); end
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_back_to_back();
        req = 3'b001; number_bus = {8'h00, 8'h00, 8'h10}; op_bus = 6'b000000;
        tick();
        req = 3'b000;
        total++;
        if (gnt !== 3'b001) begin bad++; $display("FAIL b2b_gnt0 got=%b want=001", gnt); end
        tick();
        number_bus = {8'h00, 8'h66, 8'h99}; req = 3'b010; op_bus = 6'b000100;
        tick();
        total++;
        if ({rsp_valid, rsp_data} !== {3'b001, 8'h11}) begin
            bad++; $display("FAIL b2b_rsp0 got=%b/%h want=001/11", rsp_valid, rsp_data);
        end
        tick();
        total++;
        if (gnt !== 3'b000) begin bad++; $display("FAIL b2b_t4 got=%b want=000", gnt); end
        tick();
        req = 3'b000;
        total++;
        if (gnt !== 3'b010) begin bad++; $display("FAIL b2b_gnt1 got=%b want=010", gnt); end
        tick(); tick();
        total++;
        if ({rsp_valid, rsp_data} !== {3'b010, 8'h66}) begin
            bad++; $display("FAIL b2b_rsp1 got=%b/%h want=010/66", rsp_valid, rsp_data);
        end
        tick();
    endtask

    task automatic test_abort();
        req = 3'b001; number_bus = {8'h00, 8'h00, 8'h30}; op_bus = 6'b000010;
        tick();
        req = 3'b000;
        tick();
        RST = 1'b0;
        #1;
        total++;
        if ({gnt, rsp_valid, rsp_err, busy, dp_number, dp_select, rsp_data} !== {8'h00, 8'h00, 2'b01, 8'h00}) begin
            bad++; $display("FAIL abort_outputs got=%b/%b/%b/%b/%h/%b/%h", gnt, rsp_valid, rsp_err, busy, dp_number, dp_select, rsp_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({rsp_valid, busy} !== 4'b0000) begin
                bad++; $display("FAIL abort_hold[%0d] got=%b want=0000", i, {rsp_valid, busy});
            end
        end
        RST = 1'b1;
        req = 3'b001;
        tick();
        req = 3'b000;
        total++;
        if (gnt !== 3'b001) begin bad++; $display("FAIL abort_regnt got=%b want=001", gnt); end
        tick(); tick();
        total++;
        if ({rsp_valid, rsp_data, rsp_err} !== {3'b001, 8'h2F, 1'b0}) begin
            bad++; $display("FAIL abort_rsp got=%b/%h/%b want=001/2f/0", rsp_valid, rsp_data, rsp_err);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_reserved();
        test_drop();
        test_fairness();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/incdec_sched.md
INCDEC_SCHED -- requirements
Module: incdec_sched

Interface
REQ-001 Parameter W, default 8, operand/result width in bits.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 RST  in  1  asynchronous, active-low reset.
REQ-004 req  in  3  per-requester request, bit i = requester i.
REQ-005 number_bus  in  3*W  operands, requester i at bits [i*W +: W].
REQ-006 op_bus  in  6  op codes, requester i at bits [2i +: 2]; 00 increment, 01 pass, 10 decrement, 11 reserved.
REQ-007 gnt  out  3  one-hot, one-cycle grant pulse.
REQ-008 dp_number  out  W  operand to the shared registered inc/pass/dec datapath.
REQ-009 dp_select  out  2  op to the shared datapath.
REQ-010 dp_result  in  W  registered datapath output, valid one clock after dp_number/dp_select.
REQ-011 rsp_valid  out  3  one-hot, one-cycle response pulse to the owning requester.
REQ-012 rsp_data  out  W  response value, valid while any rsp_valid bit is 1.
REQ-013 rsp_err  out  1  reserved-op flag, valid with rsp_valid.
REQ-014 busy  out  1  1 in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; transitions IDLE->ISSUE when req != 0, else stay; ISSUE->WAIT, WAIT->RESP, RESP->IDLE unconditionally.
REQ-016 In IDLE with req != 0, the winner SHALL be the first set req bit scanning from (ptr+1) mod 3 upward, wrapping.
REQ-017 On the IDLE->ISSUE edge the block SHALL latch winner index, its operand and its op, set ptr = winner, and register gnt[winner] = 1 for the ISSUE cycle only.
REQ-018 In ISSUE, dp_number SHALL equal the latched operand and dp_select the latched op, except op 11 drives dp_select = 01.
REQ-019 Outside ISSUE, dp_number SHALL be 0 and dp_select 01.
REQ-020 On the WAIT->RESP edge, dp_result SHALL be captured into a result register.
REQ-021 In RESP, rsp_valid[winner] = 1; rsp_data = captured result, or 0 when latched op is 11; rsp_err = 1 only when latched op is 11.
REQ-022 Outside RESP, rsp_valid = 0, rsp_data = 0, rsp_err = 0.
REQ-023 Latency: request sampled in IDLE cycle t -> gnt at t+1 -> rsp_valid at t+3; next arbitration at t+4; one operation per 4 cycles max.
REQ-024 req, number_bus, op_bus SHALL be sampled only in IDLE; changes in ISSUE/WAIT/RESP are ignored.
REQ-025 A requester dropping req before being sampled SHALL receive no grant and no response.
REQ-026 Arithmetic wrap is the datapath's: 0xFF increment -> 0x00, 0x00 decrement -> 0xFF, passed through unmodified.
REQ-027 A requester holding req continuously SHALL get at most one grant per arbitration round while others request.

Reset
REQ-028 RST low SHALL asynchronously force state IDLE, ptr = 2 (requester 0 first priority), gnt = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, busy = 0, dp_number = 0, dp_select = 01, latched registers = 0.
REQ-029 RST asserted mid-operation SHALL abort it with no rsp_valid pulse; first arbitration after release occurs in the first IDLE cycle with RST high.

Verification
REQ-030 Single: req=001, number0=0x41, op0=00 -> gnt=001 at t+1, dp_number=0x41/dp_select=00 at t+1, rsp_valid=001 with rsp_data=0x42 at t+3.
REQ-031 Wrap: req=010, number1=0xFF, op1=00 -> rsp_data=0x00; number1=0x00, op1=10 -> rsp_data=0xFF.
REQ-032 Fairness: req=111 held after reset -> grant order 001, 010, 100, 001, spaced 4 cycles.
REQ-033 Reserved op: req=100, op2=11, number2=0x55 -> dp_select=01 in ISSUE, rsp_valid=100, rsp_data=0x00, rsp_err=1 at t+3.
REQ-034 Ignore: req=001 granted, then number0 changed and req=010 raised during WAIT -> rsp_data from original operand; requester 1 granted at t+5.
REQ-035 Abort: RST low during WAIT -> no rsp_valid, all outputs at reset values; after release req=001 -> normal response 3 cycles after grant-sample.
